// File: rtl/mem_access_master_if.sv
// Processor-side request/response and memory bus signals of the memory access master.
interface mem_access_master_if #(
    parameter int W = 16
);
    logic         fetch_req;
    logic [W-1:0] pc;
    logic         data_req;
    logic         data_we;
    logic [W-1:0] alu_out;
    logic [W-1:0] wr_data;
    logic [W-1:0] Memdata;
    logic [W-1:0] Address;
    logic [W-1:0] Writedata;
    logic         MemRead;
    logic         MemWrite;
    logic [W-1:0] instr;
    logic [W-1:0] mdr;
    logic         fetch_done;
    logic         data_done;
    logic         busy;

    modport master (
        input  fetch_req, pc, data_req, data_we, alu_out, wr_data, Memdata,
        output Address, Writedata, MemRead, MemWrite, instr, mdr,
               fetch_done, data_done, busy
    );

    modport slave (
        output fetch_req, pc, data_req, data_we, alu_out, wr_data, Memdata,
        input  Address, Writedata, MemRead, MemWrite, instr, mdr,
               fetch_done, data_done, busy
    );
endinterface

// File: rtl/mem_access_master.sv
// Arbitrates fetch and load/store requests onto a single memory port with a fixed wait time.
//   state  | meaning
//   IDLE   | no access on the bus; strobes low, Address/Writedata hold
//   ACCESS | strobe held for WAIT_CYCLES cycles, wait_cnt counts down to 0
module mem_access_master #(
    parameter int WAIT_CYCLES = 1,
    parameter int W           = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    mem_access_master_if.master  bus
);
    typedef enum logic {IDLE, ACCESS} state_t;

    localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

    state_t       state;
    logic [3:0]   wait_cnt;
    logic         fetch_pend;
    logic         data_pend;
    logic [W-1:0] fetch_addr;
    logic [W-1:0] data_addr;
    logic [W-1:0] data_wdata;
    logic         data_st;
    logic         cur_fetch;

    assign bus.busy = (state != IDLE) | fetch_pend | data_pend;

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            wait_cnt       <= '0;
            fetch_pend     <= 1'b0;
            data_pend      <= 1'b0;
            fetch_addr     <= '0;
            data_addr      <= '0;
            data_wdata     <= '0;
            data_st        <= 1'b0;
            cur_fetch      <= 1'b0;
            bus.Address    <= '0;
            bus.Writedata  <= '0;
            bus.MemRead    <= 1'b0;
            bus.MemWrite   <= 1'b0;
            bus.instr      <= '0;
            bus.mdr        <= '0;
            bus.fetch_done <= 1'b0;
            bus.data_done  <= 1'b0;
        end else begin
            bus.fetch_done <= 1'b0;
            bus.data_done  <= 1'b0;

            if (bus.fetch_req && !fetch_pend) begin
                fetch_pend <= 1'b1;
                fetch_addr <= bus.pc;
            end
            if (bus.data_req && !data_pend) begin
                data_pend  <= 1'b1;
                data_addr  <= bus.alu_out;
                data_wdata <= bus.wr_data;
                data_st    <= bus.data_we;
            end

            case (state)
                IDLE: begin
                    // A pulse in this very cycle is taken straight from the inputs.
                    if (data_pend || bus.data_req) begin
                        state     <= ACCESS;
                        wait_cnt  <= CNT_LOAD;
                        cur_fetch <= 1'b0;
                        data_pend <= 1'b0;
                        if (data_pend) begin
                            bus.Address   <= data_addr;
                            bus.Writedata <= data_wdata;
                            bus.MemRead   <= ~data_st;
                            bus.MemWrite  <= data_st;
                        end else begin
                            bus.Address   <= bus.alu_out;
                            bus.Writedata <= bus.wr_data;
                            bus.MemRead   <= ~bus.data_we;
                            bus.MemWrite  <= bus.data_we;
                        end
                    end else if (fetch_pend || bus.fetch_req) begin
                        state        <= ACCESS;
                        wait_cnt     <= CNT_LOAD;
                        cur_fetch    <= 1'b1;
                        fetch_pend   <= 1'b0;
                        bus.Address  <= fetch_pend ? fetch_addr : bus.pc;
                        bus.MemRead  <= 1'b1;
                        bus.MemWrite <= 1'b0;
                    end
                end
                ACCESS: begin
                    if (wait_cnt == 4'd0) begin
                        state        <= IDLE;
                        bus.MemRead  <= 1'b0;
                        bus.MemWrite <= 1'b0;
                        if (cur_fetch) begin
                            bus.instr      <= bus.Memdata;
                            bus.fetch_done <= 1'b1;
                        end else begin
                            if (!bus.MemWrite) begin
                                bus.mdr <= bus.Memdata;
                            end
                            bus.data_done <= 1'b1;
                        end
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_master.sv
// Runs three instances (WAIT_CYCLES 1, 3, 4) on shared stimulus against a cycle-timeline reference model.
module tb_mem_access_master;
    logic        clk = 1'b0;
    logic        t_rst, t_frq, t_drq, t_we;
    logic [15:0] t_pc, t_alu, t_wd, t_md;
    int          n_checks = 0;
    int          n_errors = 0;

    always #5 clk = ~clk;

    mem_access_master_if #(.W(16)) b1 ();
    mem_access_master_if #(.W(16)) b3 ();
    mem_access_master_if #(.W(16)) b4 ();

    assign b1.fetch_req = t_frq;  assign b3.fetch_req = t_frq;  assign b4.fetch_req = t_frq;
    assign b1.pc        = t_pc;   assign b3.pc        = t_pc;   assign b4.pc        = t_pc;
    assign b1.data_req  = t_drq;  assign b3.data_req  = t_drq;  assign b4.data_req  = t_drq;
    assign b1.data_we   = t_we;   assign b3.data_we   = t_we;   assign b4.data_we   = t_we;
    assign b1.alu_out   = t_alu;  assign b3.alu_out   = t_alu;  assign b4.alu_out   = t_alu;
    assign b1.wr_data   = t_wd;   assign b3.wr_data   = t_wd;   assign b4.wr_data   = t_wd;
    assign b1.Memdata   = t_md;   assign b3.Memdata   = t_md;   assign b4.Memdata   = t_md;

    mem_access_master #(.WAIT_CYCLES(1), .W(16)) u_w1 (.clk(clk), .rst(t_rst), .bus(b1));
    mem_access_master #(.WAIT_CYCLES(3), .W(16)) u_w3 (.clk(clk), .rst(t_rst), .bus(b3));
    mem_access_master #(.WAIT_CYCLES(4), .W(16)) u_w4 (.clk(clk), .rst(t_rst), .bus(b4));

    // Reference model: each transaction is a start cycle s; ACCESS spans s..s+wc-1,
    // done is cycle s+wc, and the next one may start no earlier than s+wc+1.
    int          wc[3] = '{1, 3, 4};
    int          ncyc;
    logic        pf[3], pd[3], pd_we[3], act[3], c_fetch[3], c_we[3];
    logic [15:0] pf_addr[3], pd_addr[3], pd_data[3];
    logic [15:0] e_addr[3], e_wd[3], e_instr[3], e_mdr[3];
    int          s_cyc[3], free_at[3];

    task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", tag, ncyc, got, exp);
        end
    endtask

    task automatic model_reset(input int i);
        pf[i] = 0; pd[i] = 0; pd_we[i] = 0; act[i] = 0; c_fetch[i] = 0; c_we[i] = 0;
        pf_addr[i] = 0; pd_addr[i] = 0; pd_data[i] = 0;
        e_addr[i] = 0; e_wd[i] = 0; e_instr[i] = 0; e_mdr[i] = 0;
        s_cyc[i] = 0; free_at[i] = 0;
    endtask

    task automatic model_step(input int i);
        if (t_rst) begin
            model_reset(i);
        end else begin
            if (act[i] && ncyc == s_cyc[i] + wc[i] - 1 && !c_we[i]) begin
                if (c_fetch[i]) e_instr[i] = t_md;
                else            e_mdr[i]   = t_md;
            end
            if (t_frq && !pf[i]) begin pf[i] = 1; pf_addr[i] = t_pc; end
            if (t_drq && !pd[i]) begin
                pd[i] = 1; pd_addr[i] = t_alu; pd_data[i] = t_wd; pd_we[i] = t_we;
            end
            if (ncyc + 1 >= free_at[i] && (pd[i] || pf[i])) begin
                act[i] = 1; s_cyc[i] = ncyc + 1; free_at[i] = ncyc + 2 + wc[i];
                if (pd[i]) begin
                    c_fetch[i] = 0; c_we[i] = pd_we[i]; e_addr[i] = pd_addr[i];
                    e_wd[i] = pd_data[i]; pd[i] = 0;
                end else begin
                    c_fetch[i] = 1; c_we[i] = 0; e_addr[i] = pf_addr[i]; pf[i] = 0;
                end
            end
        end
    endtask

    task automatic check_inst(input int i, input logic [15:0] addr, wd, ins, mdr,
                              input logic mr, mw, fd, dd, bsy);
        logic  in_acc, at_done;
        string p;
        p       = $sformatf("w%0d", wc[i]);
        in_acc  = act[i] && ncyc >= s_cyc[i] && ncyc <= s_cyc[i] + wc[i] - 1;
        at_done = act[i] && ncyc == s_cyc[i] + wc[i];
        check_val({p, " Address"},    addr, e_addr[i]);
        check_val({p, " Writedata"},  wd, e_wd[i]);
        check_val({p, " instr"},      ins, e_instr[i]);
        check_val({p, " mdr"},        mdr, e_mdr[i]);
        check_val({p, " MemRead"},    {15'b0, mr},  {15'b0, in_acc && !c_we[i]});
        check_val({p, " MemWrite"},   {15'b0, mw},  {15'b0, in_acc && c_we[i]});
        check_val({p, " fetch_done"}, {15'b0, fd},  {15'b0, at_done && c_fetch[i]});
        check_val({p, " data_done"},  {15'b0, dd},  {15'b0, at_done && !c_fetch[i]});
        check_val({p, " busy"},       {15'b0, bsy}, {15'b0, in_acc || pf[i] || pd[i]});
    endtask

    task automatic cycle(input logic frq, input logic [15:0] fpc, input logic drq,
                         input logic we, input logic [15:0] da, input logic [15:0] dw,
                         input logic r, input logic [15:0] md);
        t_frq = frq; t_pc = fpc; t_drq = drq; t_we = we;
        t_alu = da; t_wd = dw; t_rst = r; t_md = md;
        @(negedge clk);
        check_inst(0, b1.Address, b1.Writedata, b1.instr, b1.mdr,
                   b1.MemRead, b1.MemWrite, b1.fetch_done, b1.data_done, b1.busy);
        check_inst(1, b3.Address, b3.Writedata, b3.instr, b3.mdr,
                   b3.MemRead, b3.MemWrite, b3.fetch_done, b3.data_done, b3.busy);
        check_inst(2, b4.Address, b4.Writedata, b4.instr, b4.mdr,
                   b4.MemRead, b4.MemWrite, b4.fetch_done, b4.data_done, b4.busy);
        for (int i = 0; i < 3; i++) model_step(i);
        ncyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(0, 0, 0, 0, 0, 0, 0, 16'($urandom));
    endtask

    initial begin
        t_rst = 1; t_frq = 0; t_drq = 0; t_we = 0; t_pc = 0; t_alu = 0; t_wd = 0; t_md = 0;
        ncyc = 0;
        for (int i = 0; i < 3; i++) model_reset(i);
        @(posedge clk);
        #1;
        cycle(0, 0, 0, 0, 0, 0, 1, 16'h5555);
        idle(2);

        // Single fetch, WAIT_CYCLES=1
        cycle(1, 16'h0004, 0, 0, 0, 0, 0, 16'hAAAA);
        check_val("r038 addr", b1.Address, 16'h0004);
        check_val("r038 read", {15'b0, b1.MemRead}, 16'h0001);
        cycle(0, 0, 0, 0, 0, 0, 0, 16'h1234);
        check_val("r038 done", {15'b0, b1.fetch_done}, 16'h0001);
        check_val("r038 instr", b1.instr, 16'h1234);
        idle(8);

        // Store then load of the same address
        cycle(0, 0, 1, 1, 16'h0010, 16'hBEEF, 0, 16'h7777);
        check_val("r039 wr", {15'b0, b1.MemWrite}, 16'h0001);
        check_val("r039 wdata", b1.Writedata, 16'hBEEF);
        idle(8);
        cycle(0, 0, 1, 0, 16'h0010, 16'h0000, 0, 16'h0BAD);
        idle(8);

        // Simultaneous requests, then duplicate fetch while one is pending
        cycle(1, 16'h0100, 1, 0, 16'h0200, 16'h1111, 0, 16'h2222);
        idle(12);
        cycle(1, 16'h0300, 1, 1, 16'h0400, 16'h3333, 0, 16'h4444);
        cycle(1, 16'h0500, 0, 0, 0, 0, 0, 16'h6666);
        idle(12);

        // Reset during the 2nd ACCESS cycle of the WAIT_CYCLES=3 instance, data pending
        cycle(0, 0, 1, 0, 16'h0020, 16'h0000, 0, 16'h1357);
        cycle(0, 0, 1, 1, 16'h0030, 16'h9999, 0, 16'h2468);
        cycle(0, 0, 0, 0, 0, 0, 1, 16'h0F0F);
        check_val("r042 read", {15'b0, b3.MemRead}, 16'h0000);
        check_val("r042 busy", {15'b0, b3.busy}, 16'h0000);
        check_val("r042 done", {15'b0, b3.data_done}, 16'h0000);
        idle(6);

        for (int k = 0; k < 900; k++) begin
            cycle(logic'($urandom_range(3) == 0), 16'($urandom),
                  logic'($urandom_range(3) == 0), logic'($urandom_range(1)),
                  16'($urandom), 16'($urandom),
                  logic'($urandom_range(99) == 0), 16'($urandom));
        end
        idle(20);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/mem_access_master.md
MEM_ACCESS_MASTER -- requirements
Module: mem_access_master

Interface
REQ-001 The block SHALL expose parameter WAIT_CYCLES, default 1, meaning ACCESS-state cycles per memory transaction (legal 1..15).
REQ-002 The block SHALL expose parameter W, default 16, meaning address and data width.
REQ-003 Port clk, input, 1 bit: single clock; all state SHALL update on its rising edge.
REQ-004 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 Port fetch_req, input, 1 bit: one-cycle instruction-fetch request pulse.
REQ-006 Port pc, input, W bits: fetch address, sampled with fetch_req.
REQ-007 Port data_req, input, 1 bit: one-cycle load/store request pulse.
REQ-008 Port data_we, input, 1 bit: store when 1, load when 0, sampled with data_req.
REQ-009 Port alu_out, input, W bits: data address, sampled with data_req.
REQ-010 Port wr_data, input, W bits: store data, sampled with data_req.
REQ-011 Port Memdata, input, W bits: read data returned by the memory.
REQ-012 Port Address, output, W bits: memory address.
REQ-013 Port Writedata, output, W bits: memory write data.
REQ-014 Port MemRead, output, 1 bit: memory read strobe.
REQ-015 Port MemWrite, output, 1 bit: memory write strobe.
REQ-016 Port instr, output, W bits: captured fetch word.
REQ-017 Port mdr, output, W bits: captured load word.
REQ-018 Port fetch_done, output, 1 bit: one-cycle fetch-complete pulse.
REQ-019 Port data_done, output, 1 bit: one-cycle load/store-complete pulse.
REQ-020 Port busy, output, 1 bit: high when a transaction is pending or in flight.

Function
REQ-021 FSM SHALL have states IDLE and ACCESS; the block SHALL keep a wait counter and pending bits fetch_pend and data_pend.
REQ-022 fetch_req=1 with fetch_pend=0 SHALL set fetch_pend and latch pc; fetch_req=1 with fetch_pend=1 SHALL be ignored, keeping the first request.
REQ-023 data_req SHALL follow the same rule, latching alu_out, wr_data and data_we together.
REQ-024 In IDLE with any pending bit set, the next edge SHALL enter ACCESS, clear the selected pending bit, drive Address and Writedata from the latch, and load the counter with WAIT_CYCLES-1.
REQ-025 Selection SHALL be data_pend before fetch_pend; a pulse arriving in the IDLE cycle itself SHALL be eligible at that same edge.
REQ-026 In ACCESS, MemRead SHALL equal the inverse of the store flag and MemWrite SHALL equal the store flag, both held with stable Address and Writedata for exactly WAIT_CYCLES cycles.
REQ-027 On the edge ending the last ACCESS cycle (counter=0), a load SHALL capture Memdata into mdr and a fetch SHALL capture it into instr; the FSM SHALL return to IDLE.
REQ-028 A store SHALL NOT modify mdr or instr.
REQ-029 The matching done output SHALL be high for exactly the one cycle after the last ACCESS cycle.
REQ-030 Latency: with a request pulse in cycle t and the FSM idle with no other pending request, ACCESS SHALL occupy cycles t+1..t+WAIT_CYCLES and done SHALL assert in cycle t+WAIT_CYCLES+1.
REQ-031 The next pending transaction SHALL enter ACCESS on the edge after the done cycle begins, i.e. a 1-cycle IDLE gap between transactions.
REQ-032 In IDLE, MemRead and MemWrite SHALL be 0, and Address and Writedata SHALL hold their last driven values.
REQ-033 busy SHALL equal (state!=IDLE) | fetch_pend | data_pend.
REQ-034 A request pulse arriving during ACCESS of the same type SHALL be latched as a new pending request.

Reset
REQ-035 rst=1 at an edge SHALL force IDLE, clear both pending bits and the counter, and set Address, Writedata, instr and mdr to 0, and MemRead, MemWrite, fetch_done, data_done and busy to 0.
REQ-036 rst asserted mid-ACCESS SHALL deassert both strobes at that edge, suppress the done pulse, and discard pending requests.
REQ-037 Request pulses coincident with rst SHALL be dropped.

Verification
REQ-038 Fetch, WAIT_CYCLES=1: pc=0x0004 pulsed in cycle 0, Memdata=0x1234 -> cycle 1 shows Address=0x0004 and MemRead=1; cycle 2 shows fetch_done=1 and instr=0x1234.
REQ-039 Store then load: store addr=0x0010, data=0xBEEF -> one MemWrite cycle with Writedata=0xBEEF and mdr unchanged; then load of 0x0010 -> mdr=Memdata and data_done pulses once.
REQ-040 Simultaneous fetch_req and data_req in IDLE -> data access runs first, then fetch; busy stays high throughout; two done pulses 2 cycles apart (WAIT_CYCLES=1).
REQ-041 A duplicate fetch_req while fetch_pend=1 -> only one fetch is issued, with the first pc.
REQ-042 rst in the 2nd ACCESS cycle (WAIT_CYCLES=3) with data pending -> strobes low next cycle, no done pulse, busy=0.
REQ-043 WAIT_CYCLES=4 -> MemRead high exactly 4 cycles, with Address stable across all 4.
